// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue controller.
//   - op_mne_e : mnemonics of the opcodes that are executed on the external ALU
//   - OPC_LDI  : load-immediate opcode, handled locally without the ALU
//   - state_e  : issue FSM states
//   - is_illegal() : true for opcodes 101..111
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_XOR = 3'b010,
    OP_SRL = 3'b011
  } op_mne_e;

  localparam logic [2:0] OPC_LDI = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    RETIRE
  } state_e;

  function automatic logic is_illegal(input logic [2:0] opc);
    return (opc > OPC_LDI);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Groups the instruction handshake, the external-ALU bus, the retire
//   status pulses and the debug read port of the issue controller.
//   Ports (slave = controller side):
//     instr[8:0]  in   opcode[8:6], rd[5:3], rs/imm[2:0]
//     instr_valid in   instr is valid this cycle
//     instr_ready out  controller accepts instr this cycle
//     alu_op      out  operation issued to the external ALU
//     alu_in_a/b  out  ALU operands
//     alu_out     in   combinational ALU result
//     alu_en      out  alu_out is written back this cycle
//     done / err  out  retire pulse / illegal-opcode pulse
//     rd_sel      in   debug register select
//     rd_data     out  combinational contents of R[rd_sel]
interface alu_issue_ctrl_if #(
  parameter int W = 8
);

  logic [8:0]   instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_in_a;
  logic [W-1:0] alu_in_b;
  logic [W-1:0] alu_out;
  logic         alu_en;
  logic         done;
  logic         err;
  logic [2:0]   rd_sel;
  logic [W-1:0] rd_data;

  modport master (
    output instr, instr_valid, alu_out, rd_sel,
    input  instr_ready, alu_op, alu_in_a, alu_in_b, alu_en, done, err, rd_data
  );

  modport slave (
    input  instr, instr_valid, alu_out, rd_sel,
    output instr_ready, alu_op, alu_in_a, alu_in_b, alu_en, done, err, rd_data
  );

endinterface

// File: rtl/alu_issue_ctrl_reg_file8.sv
// reg_file8
//   NREG x W register file with one synchronous write port, two
//   combinational operand read ports and one combinational debug read port.
//   Reads return the pre-write value during a write cycle.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low clear of all registers
//     we, waddr, wdata    write port
//     ra_addr / ra_data   operand A read port
//     rb_addr / rb_data   operand B read port
//     dbg_addr / dbg_data debug read port
module reg_file8 #(
  parameter int NREG = 8,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [2:0]   ra_addr,
  output logic [W-1:0] ra_data,
  input  logic [2:0]   rb_addr,
  output logic [W-1:0] rb_data,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Accepts one 9-bit instruction at a time, issues it to an external
//   combinational ALU and writes the result back into an 8-entry register
//   file. SRL is performed as a sequence of one-bit ALU passes.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_issue_ctrl_if.slave (handshake, ALU bus, status, debug read)
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus
);

  state_e       state;
  logic [8:0]   instr_q;
  logic [2:0]   cnt;
  logic         done_q;
  logic         err_q;

  logic [2:0]   opc;
  logic [2:0]   rd;
  logic [2:0]   rs;
  logic [2:0]   in_opc;
  logic [2:0]   in_imm;

  logic         we;
  logic [W-1:0] wdata;
  logic [W-1:0] ra_data;
  logic [W-1:0] rb_data;

  assign opc    = instr_q[8:6];
  assign rd     = instr_q[5:3];
  assign rs     = instr_q[2:0];
  assign in_opc = bus.instr[8:6];
  assign in_imm = bus.instr[2:0];

  reg_file8 #(
    .NREG (NREG),
    .W    (W)
  ) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (rd),
    .wdata    (wdata),
    .ra_addr  (rd),
    .ra_data  (ra_data),
    .rb_addr  (rs),
    .rb_data  (rb_data),
    .dbg_addr (bus.rd_sel),
    .dbg_data (bus.rd_data)
  );

  // ALU bus and write-back are decoded from the registered state and the
  // captured instruction; the ALU result must come straight back the same
  // cycle, so this path cannot be registered.
  always_comb begin
    bus.alu_op   = OP_ADD;
    bus.alu_in_a = '0;
    bus.alu_in_b = '0;
    bus.alu_en   = 1'b0;
    we           = 1'b0;
    wdata        = bus.alu_out;
    case (state)
      EXEC: begin
        if (opc == OP_ADD || opc == OP_AND || opc == OP_XOR) begin
          bus.alu_op   = opc;
          bus.alu_in_a = ra_data;
          bus.alu_in_b = rb_data;
          bus.alu_en   = 1'b1;
          we           = 1'b1;
        end else if (opc == OPC_LDI) begin
          we    = 1'b1;
          wdata = W'(rs);
        end
      end
      SHIFT: begin
        bus.alu_op   = OP_SRL;
        bus.alu_in_a = ra_data;
        bus.alu_in_b = W'(1);
        bus.alu_en   = 1'b1;
        we           = 1'b1;
      end
      default: ;
    endcase
  end

  // Issue FSM; done/err are registered so they rise together with RETIRE.
  // SRL by 0 skips straight to RETIRE, SRL by n loads the counter and
  // spends n cycles in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      instr_q <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            if (in_opc == OP_SRL) begin
              if (in_imm != 3'd0) begin
                cnt   <= in_imm;
                state <= SHIFT;
              end else begin
                state  <= RETIRE;
                done_q <= 1'b1;
              end
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          state  <= RETIRE;
          done_q <= 1'b1;
          err_q  <= is_illegal(opc);
        end
        SHIFT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state  <= RETIRE;
            done_q <= 1'b1;
          end
        end
        RETIRE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL provide parameter NREG, default 8, the register count; it is fixed at 8 because of 3-bit register fields.
REQ-002 The block SHALL provide parameter W, default 8, the data width.
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Instr  in  9  instruction: [8:6] opcode, [5:3] rd, [2:0] rs/imm.
REQ-006 InstrValid  in  1  Instr is valid this cycle.
REQ-007 InstrReady  out  1  block accepts Instr this cycle.
REQ-008 AluOp  out  3  op_mne issued to the external ALU.
REQ-009 AluInA / AluInB  out  W each  ALU operands.
REQ-010 AluOut  in  W  combinational ALU result for the current AluOp/operands.
REQ-011 AluEn  out  1  high on every cycle whose AluOut is written back.
REQ-012 Done  out  1  one-cycle pulse when an instruction retires.
REQ-013 Err  out  1  one-cycle pulse, coincident with Done, when the retiring instruction is illegal.
REQ-014 RdSel  in  3  debug read select.
REQ-015 RdData  out  W  combinational contents of R[RdSel].

Function
REQ-016 The block SHALL decode opcodes as follows: 000 ADD, R[rd]=R[rd]+R[rs] mod 2^W; 001 AND; 010 XOR; 011 SRL, R[rd]>>=imm, logical; 100 LDI, R[rd]={5'b0,imm}; 101-111 illegal.
REQ-017 The FSM SHALL have exactly the states IDLE, EXEC, SHIFT, RETIRE.
REQ-018 InstrReady SHALL be 1 only in IDLE; an instruction is accepted when InstrValid&&InstrReady, and Instr is captured into an internal register on that edge.
REQ-019 On accept, the next state SHALL be:
- ADD/AND/XOR/LDI/illegal: EXEC.
- SRL with imm!=0: SHIFT, with the counter loaded to imm.
- SRL with imm==0: RETIRE, with no register write.
REQ-020 EXEC SHALL last one cycle and then go to RETIRE.
- ADD/AND/XOR: AluOp=op, AluInA=R[rd], AluInB=R[rs], AluEn=1, R[rd]<=AluOut at the end of the cycle.
- LDI: AluEn=0, R[rd]<=imm.
- Illegal: no write.
REQ-021 SHIFT SHALL drive AluOp=SRL, AluInA=R[rd], AluInB=1 and AluEn=1 each cycle (one-bit shift per ALU pass); R[rd]<=AluOut, counter decrements, and the state goes to RETIRE when the counter reaches 1 before the decrement, so SRL by n takes n SHIFT cycles.
REQ-022 RETIRE SHALL assert Done=1, assert Err=1 iff the opcode is illegal, and go to IDLE the next cycle.
REQ-023 Latency from accept edge to Done:
- 2 cycles for ALU ops, LDI and illegal.
- n+1 cycles for SRL by n≥1.
- 1 cycle for SRL 0.
REQ-024 Outside EXEC/SHIFT, AluEn SHALL be 0, AluOp SHALL be ADD, and AluInA and AluInB SHALL be 0.
REQ-025 InstrValid while InstrReady=0 SHALL be ignored; an instruction held valid SHALL be accepted on the first IDLE cycle.
REQ-026 A register write and a RdSel read of the same register in the same cycle SHALL return the old value; the new value is visible the next cycle.
REQ-027 When rd==rs, ADD/AND/XOR SHALL use R[rd] for both operands (for example XOR clears the register).

Reset
REQ-028 When Reset_n is low, asynchronously: state=IDLE, all registers=0, counter=0, captured Instr=0, Done=0, Err=0.
REQ-029 Reset asserted mid-SHIFT or mid-EXEC SHALL abandon the instruction with no further writes and no Done.
REQ-030 The first accept SHALL be possible on the first rising Clk edge after Reset_n rises.

Structure
REQ-031 The Definitions package SHALL hold the op_mne enum and a new FSM state typedef; the LDI opcode constant SHALL be added there.
REQ-032 The register file SHALL be the sub-module reg_file8: NREG x W, one combinational debug read port, two combinational operand read ports, one synchronous write port, async-low clear.

Verification
REQ-033 The bench SHALL cover these scenarios:
- LDI R1,5 then LDI R2,3 then ADD R1,R2 -> Done 2 cycles after each accept; RdData(R1)=8; AluEn high for exactly one cycle in the ADD.
- LDI R3,7; ADD R3,R3 x5 (R3=224); SRL R3,5 -> 5 SHIFT cycles with AluEn=1, AluInB=1; Done at accept+6; R3=7.
- SRL R4,0 -> Done at accept+1; no AluEn; R4 unchanged.
- Opcode 110 -> Done and Err both pulse at accept+2; all registers unchanged.
- InstrValid held high with back-to-back LDI/XOR R5,R5 -> second accepted the cycle after Done; R5=0.
- Reset_n pulsed low during the 3rd SHIFT cycle of SRL by 6 -> no Done; all registers 0; InstrReady=1 after release.
